// File: rtl/zbuf_depth_ctrl_if.sv
// zbuf_depth_ctrl_if: fragment input, z-cache read/write and pass output signals of the depth controller
interface zbuf_depth_ctrl_if;
    logic        frag_valid;
    logic        frag_ready;
    logic [18:0] frag_in_id;
    logic [15:0] frag_in_z;
    logic [31:0] frag_in_attr;
    logic [18:0] frag_id;
    logic        frag_rd_en;
    logic        frag_hit;
    logic [15:0] frag_zval;
    logic [18:0] update_id;
    logic        update_en;
    logic [15:0] update_val;
    logic        update_hit;
    logic        pass_valid;
    logic        pass_ready;
    logic [18:0] pass_id;
    logic [31:0] pass_attr;
    modport slave (
        input  frag_valid, frag_in_id, frag_in_z, frag_in_attr, frag_hit, frag_zval, update_hit, pass_ready,
        output frag_ready, frag_id, frag_rd_en, update_id, update_en, update_val, pass_valid, pass_id, pass_attr
    );
    modport master (
        output frag_valid, frag_in_id, frag_in_z, frag_in_attr, frag_hit, frag_zval, update_hit, pass_ready,
        input  frag_ready, frag_id, frag_rd_en, update_id, update_en, update_val, pass_valid, pass_id, pass_attr
    );
endinterface

// File: rtl/zbuf_depth_ctrl.sv
// zbuf_depth_ctrl: one-fragment-at-a-time depth test against a z-cache, writing back and emitting passing fragments
module zbuf_depth_ctrl #(
    parameter int LEQUAL  = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    zbuf_depth_ctrl_if.slave bus,
    output logic [15:0]      stat_pass,
    output logic [15:0]      stat_fail,
    output logic             err_timeout
);
    localparam int W = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, READ, COMPARE, UPDATE, EMIT} state_t;
    state_t state, state_d;
    logic [18:0] id_q;
    logic [15:0] z_q;
    logic [31:0] attr_q;
    logic [W-1:0] wait_q;
    logic pass_t, stalled, expire;
    assign pass_t  = (LEQUAL != 0) ? (z_q <= bus.frag_zval) : (z_q < bus.frag_zval);
    assign stalled = (state == READ && !bus.frag_hit) || (state == UPDATE && !bus.update_hit);
    // expire on the last allowed stalled cycle so at most TIMEOUT cycles are spent waiting
    assign expire  = stalled && wait_q == W'(TIMEOUT - 1);
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = bus.frag_valid ? READ : IDLE;
            READ:    state_d = bus.frag_hit ? COMPARE : expire ? IDLE : READ;
            COMPARE: state_d = pass_t ? UPDATE : IDLE;
            UPDATE:  state_d = bus.update_hit ? EMIT : expire ? IDLE : UPDATE;
            EMIT:    state_d = bus.pass_ready ? IDLE : EMIT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            id_q        <= '0;
            z_q         <= '0;
            attr_q      <= '0;
            wait_q      <= '0;
            stat_pass   <= '0;
            stat_fail   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state  <= state_d;
            wait_q <= (state_d != state) ? '0 : stalled ? wait_q + 1'b1 : wait_q;
            if (state == IDLE && bus.frag_valid) begin
                id_q   <= bus.frag_in_id;
                z_q    <= bus.frag_in_z;
                attr_q <= bus.frag_in_attr;
            end
            if (expire) err_timeout <= 1'b1;
            if (state == COMPARE && !pass_t && stat_fail != 16'hFFFF) stat_fail <= stat_fail + 1'b1;
            if (state == EMIT && bus.pass_ready && stat_pass != 16'hFFFF) stat_pass <= stat_pass + 1'b1;
        end
    end
    assign bus.frag_ready = state == IDLE;
    assign bus.frag_rd_en = state == READ;
    assign bus.frag_id    = id_q;
    assign bus.update_en  = state == UPDATE;
    assign bus.update_id  = id_q;
    assign bus.update_val = z_q;
    assign bus.pass_valid = state == EMIT;
    assign bus.pass_id    = id_q;
    assign bus.pass_attr  = attr_q;
endmodule

// File: tb/tb_zbuf_depth_ctrl.sv
// tb_zbuf_depth_ctrl: scoreboard bench for zbuf_depth_ctrl, strict-less (dut_a) and less-equal/short-timeout (dut_b)
module tb_zbuf_depth_ctrl;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic        frag_valid = 0, hit_on = 1, uhit_on = 1, pready = 1, sel = 0;
    logic [18:0] in_id = 0;
    logic [15:0] in_z = 0, zval = 0;
    logic [31:0] in_attr = 0;
    logic [15:0] sp_a, sf_a, sp_b, sf_b;
    logic        et_a, et_b;
    zbuf_depth_ctrl_if ia();
    zbuf_depth_ctrl_if ib();
    assign ia.frag_valid = frag_valid;  assign ib.frag_valid = frag_valid;
    assign ia.frag_in_id = in_id;       assign ib.frag_in_id = in_id;
    assign ia.frag_in_z = in_z;         assign ib.frag_in_z = in_z;
    assign ia.frag_in_attr = in_attr;   assign ib.frag_in_attr = in_attr;
    assign ia.frag_hit = hit_on;        assign ib.frag_hit = hit_on;
    assign ia.frag_zval = zval;         assign ib.frag_zval = zval;
    assign ia.update_hit = uhit_on;     assign ib.update_hit = uhit_on;
    assign ia.pass_ready = pready;      assign ib.pass_ready = pready;
    zbuf_depth_ctrl #(.LEQUAL(0), .TIMEOUT(1023)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave), .stat_pass(sp_a), .stat_fail(sf_a), .err_timeout(et_a));
    zbuf_depth_ctrl #(.LEQUAL(1), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave), .stat_pass(sp_b), .stat_fail(sf_b), .err_timeout(et_b));
    // outputs of whichever instance the current section exercises
    logic        o_fready, o_rd_en, o_upd_en, o_pvalid, o_et;
    logic [18:0] o_fid, o_upd_id, o_pid;
    logic [15:0] o_upd_val, o_sp, o_sf;
    logic [31:0] o_pattr;
    assign o_fready  = sel ? ib.frag_ready : ia.frag_ready;
    assign o_rd_en   = sel ? ib.frag_rd_en : ia.frag_rd_en;
    assign o_fid     = sel ? ib.frag_id : ia.frag_id;
    assign o_upd_en  = sel ? ib.update_en : ia.update_en;
    assign o_upd_id  = sel ? ib.update_id : ia.update_id;
    assign o_upd_val = sel ? ib.update_val : ia.update_val;
    assign o_pvalid  = sel ? ib.pass_valid : ia.pass_valid;
    assign o_pid     = sel ? ib.pass_id : ia.pass_id;
    assign o_pattr   = sel ? ib.pass_attr : ia.pass_attr;
    assign o_sp      = sel ? sp_b : sp_a;
    assign o_sf      = sel ? sf_b : sf_a;
    assign o_et      = sel ? et_b : et_a;
    int total = 0, bad = 0;
    int cyc = 0, acc_cyc = 0, lat = 0, upd_cnt = 0;
    logic pv_d = 0;
    logic [15:0] epass = 0, efail = 0;
    logic [34:0] q_upd[$];
    logic [50:0] q_pass[$];
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!rst) begin
            if (frag_valid && o_fready) acc_cyc = cyc;
            if (o_pvalid && !pv_d) lat = cyc - acc_cyc;
            pv_d = o_pvalid;
            if (o_upd_en) upd_cnt++;
            if (o_upd_en && uhit_on) begin
                chk("upd_pending", 64'(q_upd.size() > 0), 1);
                if (q_upd.size() > 0) chk("upd_id_val", {o_upd_id, o_upd_val}, q_upd.pop_front());
            end
            if (o_pvalid && pready) begin
                chk("pass_pending", 64'(q_pass.size() > 0), 1);
                if (q_pass.size() > 0) chk("pass_id_attr", {o_pid, o_pattr}, q_pass.pop_front());
            end
        end
    end
    task automatic clkw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 2000 && !o_fready; i++) clkw(1);
        chk("idle_wait", o_fready, 1);
    endtask
    task automatic do_reset();
        rst = 1;
        q_upd.delete();
        q_pass.delete();
        epass = 0;
        efail = 0;
        pv_d = 0;
        clkw(2);
        rst = 0;
    endtask
    task automatic send(input logic [18:0] id, input logic [15:0] z, input logic [31:0] attr, input bit drop);
        logic ok;
        ok = sel ? (z <= zval) : (z < zval);
        if (!drop && ok) begin
            q_upd.push_back({id, z});
            q_pass.push_back({id, attr});
            if (epass != 16'hFFFF) epass++;
        end else if (!drop) begin
            if (efail != 16'hFFFF) efail++;
        end
        in_id = id;
        in_z = z;
        in_attr = attr;
        frag_valid = 1;
        clkw(1);
        frag_valid = 0;
    endtask
    initial begin
        int u0;
        logic [15:0] rz;
        rst = 1;
        clkw(2);
        chk("rst_ready", o_fready, 1);
        chk("rst_outs", {o_rd_en, o_upd_en, o_pvalid, o_et}, 0);
        chk("rst_stats", {o_sp, o_sf}, 0);
        chk("rst_latched", {o_fid, o_upd_val, o_pattr}, 0);
        rst = 0;
        clkw(1);
        chk("ready_after_rst", o_fready, 1);
        // strict compare, immediate hits
        zval = 16'h0200;
        send(19'h00402, 16'h0100, 32'hCAFE0001, 0);
        wait_idle();
        chk("latency", lat, 4);
        chk("stat_pass_1", o_sp, epass);
        u0 = upd_cnt;
        send(19'h00404, 16'h0200, 32'hCAFE0002, 0);
        wait_idle();
        chk("eq_fail_no_upd", upd_cnt, u0);
        chk("stat_fail_1", o_sf, efail);
        for (int i = 0; i < 8; i++) begin
            zval = 16'($urandom_range(0, 65535));
            rz = (i % 3 == 0) ? zval : 16'($urandom_range(0, 65535));
            send(19'($urandom), rz, $urandom, 0);
            wait_idle();
        end
        chk("rand_stats", {o_sp, o_sf}, {epass, efail});
        // miss stall for 20 cycles
        zval = 16'h0800;
        hit_on = 0;
        send(19'h12345, 16'h0010, 32'h0BADBEEF, 0);
        for (int i = 0; i < 20; i++) begin
            chk("stall_rd", {o_rd_en, o_fid}, {1'b1, 19'h12345});
            clkw(1);
        end
        hit_on = 1;
        chk("stall_rd21", {o_rd_en, o_fid}, {1'b1, 19'h12345});
        clkw(1);
        chk("cmp_id_hold", {o_rd_en, o_fid}, {1'b0, 19'h12345});
        wait_idle();
        chk("stall_no_err", o_et, 0);
        chk("stall_stats", {o_sp, o_sf}, {epass, efail});
        // less-or-equal and short timeout instance
        sel = 1;
        do_reset();
        zval = 16'h0200;
        send(19'h00406, 16'h0200, 32'h5EED0001, 0);
        wait_idle();
        chk("leq_pass", {o_sp, o_sf}, {epass, efail});
        hit_on = 0;
        send(19'h00408, 16'h0001, 32'h5EED0002, 1);
        for (int i = 0; i < 8; i++) begin
            chk("to_rd", o_rd_en, 1);
            clkw(1);
        end
        chk("to_drop", {o_rd_en, o_fready, o_et}, 3'b011);
        chk("to_stats", {o_sp, o_sf}, {epass, efail});
        hit_on = 1;
        send(19'h0040A, 16'h0001, 32'h5EED0003, 0);
        wait_idle();
        chk("to_sticky", o_et, 1);
        chk("to_after", {o_sp, o_sf}, {epass, efail});
        // backpressure on the pass side
        sel = 0;
        do_reset();
        pready = 0;
        send(19'h00C0C, 16'h0001, 32'hFEED0001, 0);
        for (int i = 0; i < 50 && !o_pvalid; i++) clkw(1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {o_pvalid, o_pid, o_pattr}, {1'b1, 19'h00C0C, 32'hFEED0001});
            clkw(1);
        end
        pready = 1;
        wait_idle();
        chk("bp_done", {o_sp, 16'(q_pass.size())}, {epass, 16'h0});
        // reset while stalled in UPDATE
        uhit_on = 0;
        send(19'h00E0E, 16'h0002, 32'hFEED0002, 0);
        clkw(2);
        chk("in_update", o_upd_en, 1);
        rst = 1;
        #1;
        chk("rst_mid_outs", {o_rd_en, o_upd_en, o_pvalid, o_fready}, 4'b0001);
        chk("rst_mid_state", {o_sp, o_sf, 15'(o_et), o_upd_val}, 0);
        q_upd.delete();
        q_pass.delete();
        epass = 0;
        efail = 0;
        clkw(1);
        rst = 0;
        uhit_on = 1;
        u0 = upd_cnt;
        clkw(6);
        chk("rst_no_upd", upd_cnt, u0);
        // fail counter preloaded near its ceiling
        force dut_a.stat_fail = 16'hFFFD;
        #1;
        release dut_a.stat_fail;
        efail = 16'hFFFD;
        chk("sat_preload", o_sf, efail);
        zval = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            send(19'(i), 16'h0300, 32'(i), 0);
            wait_idle();
            chk("sat_fail", o_sf, efail);
        end
        chk("sat_final", o_sf, 16'hFFFF);
        chk("sb_empty", 64'(q_upd.size() + q_pass.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zbuf_depth_ctrl.md
ZBUF_DEPTH_CTRL -- requirements
Module: zbuf_depth_ctrl

Interface
REQ-001 SHALL have parameter LEQUAL, default 0, meaning 0 = pass if new z < stored z and 1 = pass if new z <= stored z.
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning the maximum number of cycles spent in READ or UPDATE before the fragment is dropped.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 frag_valid  input  1  upstream fragment available.
REQ-006 frag_ready  output  1  block can accept a fragment.
REQ-007 frag_in_id  input  19  fragment z-buffer ID: [18:10] tag, [9:1] word, [0] half-select.
REQ-008 frag_in_z  input  16  candidate depth.
REQ-009 frag_in_attr  input  32  opaque attribute, passed through to the output.
REQ-010 frag_id  output  19  read ID to the z-cache.
REQ-011 frag_rd_en  output  1  read request to the z-cache.
REQ-012 frag_hit  input  1  z-cache read hit, combinational on frag_id.
REQ-013 frag_zval  input  16  stored depth, valid 1 cycle after a hit cycle with frag_id held.
REQ-014 update_id  output  19  write ID to the z-cache.
REQ-015 update_en  output  1  write request to the z-cache.
REQ-016 update_val  output  16  depth to write.
REQ-017 update_hit  input  1  z-cache accepted the write this cycle.
REQ-018 pass_valid  output  1  passed fragment is available downstream.
REQ-019 pass_ready  input  1  downstream accepts the fragment.
REQ-020 pass_id  output  19  ID of the passed fragment.
REQ-021 pass_attr  output  32  attribute of the passed fragment.
REQ-022 stat_pass  output  16  count of passed fragments.
REQ-023 stat_fail  output  16  count of failed fragments.
REQ-024 err_timeout  output  1  sticky flag, set when a fragment is dropped on timeout.

Function
REQ-025 The FSM SHALL have exactly the states IDLE, READ, COMPARE, UPDATE and EMIT; one fragment in flight at a time.
REQ-026 IDLE: frag_ready=1; on frag_valid, latch id, z and attr and go to READ; frag_ready=0 in all other states.
REQ-027 READ: frag_rd_en=1 and frag_id=latched id; frag_hit=1 goes to COMPARE; frag_hit=0 stays in READ (miss stall).
REQ-028 frag_id SHALL remain equal to the latched id during COMPARE so the BRAM read result is valid.
REQ-029 COMPARE (one cycle): the pass test is an unsigned 16-bit comparison of latched z against frag_zval per LEQUAL.
REQ-030 COMPARE on pass: go to UPDATE.
REQ-031 COMPARE on fail: increment stat_fail and go to IDLE.
REQ-032 UPDATE: update_en=1, update_id=latched id, update_val=latched z; update_hit=1 goes to EMIT; otherwise hold all values.
REQ-033 EMIT: pass_valid=1 with pass_id and pass_attr stable; pass_valid&&pass_ready increments stat_pass and goes to IDLE.
REQ-034 Best-case latency SHALL be frag accept to pass_valid = 4 cycles (IDLE, READ-hit, COMPARE, UPDATE-hit, then EMIT).
REQ-035 A wait counter SHALL clear on entry to READ and UPDATE and increment each cycle stalled there.
REQ-036 When the wait counter reaches TIMEOUT, the block SHALL drop the fragment, set err_timeout and return to IDLE, with no counter increment.
REQ-037 stat_pass and stat_fail SHALL saturate at 16'hFFFF with no wrap-around.
REQ-038 frag_rd_en, update_en and pass_valid SHALL be mutually exclusive and registered-state-decoded, free of glitches from inputs.
REQ-039 frag_valid arriving outside IDLE SHALL be ignored; upstream holds it until frag_ready.

Reset
REQ-040 Asserting rst at any time, including mid-READ or mid-UPDATE, SHALL force state IDLE immediately.
REQ-041 On rst, frag_rd_en, update_en and pass_valid SHALL be 0.
REQ-042 On rst, frag_ready SHALL be 1 after deassertion.
REQ-043 On rst, stat_pass, stat_fail, err_timeout and the wait counter SHALL be 0.
REQ-044 On rst, latched id, z and attr SHALL be 0.
REQ-045 An in-flight fragment SHALL be discarded on reset without any cache write.

Verification
REQ-046 Hit, pass: id=19'h00402, z=16'h0100, cache zval=16'h0200, immediate hits -> update_val=16'h0100 to id 19'h00402, pass_valid 4 cycles after accept, stat_pass=1.
REQ-047 Hit, fail, equal: z=16'h0200, zval=16'h0200, LEQUAL=0 -> no update_en, stat_fail=1; repeat with LEQUAL=1 -> pass, stat_pass=1.
REQ-048 Miss stall: frag_hit low for 20 cycles then high -> frag_rd_en held 21 cycles, frag_id stable, then normal compare; err_timeout=0.
REQ-049 Timeout: TIMEOUT=8, frag_hit held 0 -> drop after 8 stalled cycles, err_timeout=1 sticky, counters unchanged, frag_ready=1.
REQ-050 Backpressure and reset: pass_ready=0 for 5 cycles holds pass_valid/pass_id; rst asserted during UPDATE -> all outputs at reset values that cycle, no further update_en.
REQ-051 Saturation: force 65536 failing fragments -> stat_fail=16'hFFFF and holds.
